// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one byte-level I2C master command port among
// NUM_REQ requesters. Round-robin grant on START, grant held until STOP,
// one command outstanding, forced STOP when the owner stalls in HOLD.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no grant; round-robin search for the next START
// ISSUE    | owner command presented to the master, waiting m_cmd_ready
// WAIT_RSP | command accepted by master, waiting m_rsp_valid
// HOLD     | grant held between commands, idle counter running
// FSTOP    | owner timed out, autonomous STOP presented to the master
// FWAIT    | waiting for the forced STOP completion (response discarded)
module i2c_cmd_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [3*NUM_REQ-1:0]          req_cmd,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [1:0]                    rsp_status,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          m_cmd_valid,
  output logic [2:0]                    m_cmd,
  output logic [DATA_WIDTH-1:0]         m_data,
  input  logic                          m_cmd_ready,
  input  logic                          m_rsp_valid,
  input  logic [1:0]                    m_rsp_status,
  input  logic [DATA_WIDTH-1:0]         m_rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic                          timeout_pulse
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_TIMEOUT);

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_STOP    = 3'd1;
  localparam logic [1:0] ST_ARB_LOST = 2'd2;
  localparam logic [1:0] ST_ERROR    = 2'd3;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, HOLD, FSTOP, FWAIT} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         last_grant_q, last_grant_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic                  busy_q, busy_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  timeout_q, timeout_d;

  logic [2:0]            cmd_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  pick_found;
  logic [IW-1:0]         pick_idx;
  logic [IW:0]           cand;
  logic [NUM_REQ-1:0]    ready_c;
  logic                  err_c;

  // Split the flat request buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_arr[i]  = req_cmd[3*i +: 3];
      data_arr[i] = req_data[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  // Round-robin search starting just after the last released grant.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!pick_found && req_valid[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  // Next-state and accept logic for the grant FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = '0;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    timeout_d    = 1'b0;
    ready_c      = '0;
    err_c        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          if (cmd_arr[pick_idx] != CMD_START) begin
            // A registered response may still be on the bus this cycle;
            // hold the error strobe off so the two never share rsp_status.
            if (rsp_valid_q == '0) begin
              ready_c[pick_idx] = 1'b1;
              err_c             = 1'b1;
              last_grant_d      = pick_idx;
            end
          end else begin
            ready_c[pick_idx] = 1'b1;
            owner_d           = pick_idx;
            busy_d            = 1'b1;
            cmd_d             = cmd_arr[pick_idx];
            data_d            = data_arr[pick_idx];
            state_d           = ISSUE;
          end
        end
      end
      ISSUE: if (m_cmd_ready) state_d = WAIT_RSP;
      WAIT_RSP: begin
        if (m_rsp_valid) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_status_d         = m_rsp_status;
          rsp_data_d           = m_rsp_data;
          if (m_rsp_status == ST_ARB_LOST || cmd_q == CMD_STOP) begin
            busy_d       = 1'b0;
            last_grant_d = owner_q;
            state_d      = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (req_valid[owner_q]) begin
          ready_c[owner_q] = 1'b1;
          cmd_d            = cmd_arr[owner_q];
          data_d           = data_arr[owner_q];
          state_d          = ISSUE;
        end else if (cnt_q == CW'(HOLD_TIMEOUT-1)) begin
          timeout_d = 1'b1;
          state_d   = FSTOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FSTOP: if (m_cmd_ready) state_d = FWAIT;
      FWAIT: begin
        if (m_rsp_valid) begin
          busy_d       = 1'b0;
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NUM_REQ-1);
      owner_q      <= '0;
      busy_q       <= 1'b0;
      cmd_q        <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_status_q <= '0;
      rsp_data_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      timeout_q    <= timeout_d;
    end
  end

  assign req_ready     = rst_n ? ready_c : '0;
  assign rsp_valid     = rst_n ? (rsp_valid_q | (err_c ? ready_c : '0)) : '0;
  assign rsp_status    = (rst_n && err_c) ? ST_ERROR : rsp_status_q;
  assign rsp_data      = rsp_data_q;
  assign m_cmd_valid   = (state_q == ISSUE) || (state_q == FSTOP);
  assign m_cmd         = (state_q == FSTOP) ? CMD_STOP : cmd_q;
  assign m_data        = data_q;
  assign owner         = owner_q;
  assign busy          = busy_q;
  assign timeout_pulse = timeout_q;

endmodule
